if_pc_redirect: RTL and testbench

//  Fetch-stage PC generator; the receiving end of the EX-stage branch/jump resolution outputs.

---
 rtl/if_pc_redirect_pkg.sv | 25 ++
 rtl/if_pc_redirect_fetch_buf.sv | 36 +++
 rtl/if_pc_redirect.sv | 114 +++++++++++
 tb/tb_if_pc_redirect.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_redirect_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
`ifndef IF_PC_REDIRECT_PKG_SV
`define IF_PC_REDIRECT_PKG_SV
`define RNG_64 63:0

package if_pc_redirect_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [`RNG_64] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;
    localparam int unsigned    DEFAULT_PC_INC   = 4;

    // Sequential successor address; wraps modulo 2^64.
    function automatic logic [`RNG_64] pc_step(input logic [`RNG_64] pc,
                                               input int unsigned     inc);
        return pc + 64'(inc);
    endfunction

endpackage

`endif

// File: rtl/if_pc_redirect_fetch_buf.sv
// One-entry IF->ID instruction buffer: load, hold under stall, clear when consumed or flushed.
`include "rtl/if_pc_redirect_pkg.sv"

module if_fetch_buf
    import if_pc_redirect_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            stall,
    input  logic [`RNG_64]  load_pc,
    input  logic [31:0]     load_instr,
    output logic            valid,
    output logic [`RNG_64]  pc,
    output logic [31:0]     instr
);

    // Flush beats load; an unloaded entry survives only while ID is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (!stall) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_pc_redirect.sv
// Fetch PC generator: one outstanding imem request, EX redirects, wrong-path squash.
`include "rtl/if_pc_redirect_pkg.sv"

module if_pc_redirect
    import if_pc_redirect_pkg::*;
#(
    parameter logic [`RNG_64] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned    PC_INC   = DEFAULT_PC_INC
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_ex_jump_taken,
    input  logic            i_ex_branch_taken,
    input  logic [`RNG_64]  i_ex_jump_target,
    input  logic [`RNG_64]  i_ex_branch_target,
    output logic            o_imem_req,
    output logic [`RNG_64]  o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_if_valid,
    output logic [`RNG_64]  o_if_pc,
    output logic [31:0]     o_if_instr,
    output logic            o_flush
);

    fetch_state_t   state_q, state_d;
    logic [`RNG_64] pc_q, pc_d;
    logic [`RNG_64] req_pc_q;
    logic [`RNG_64] target;
    logic           redirect;
    logic           imem_req;
    logic           grant;
    logic           buf_load;

    always_comb begin
        redirect = i_ex_jump_taken | i_ex_branch_taken;
        target   = i_ex_jump_taken ? i_ex_jump_target : i_ex_branch_target;
    end

    // A response that arrives after a redirect belongs to the wrong path; S_DROP waits it out.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        grant    = 1'b0;
        buf_load = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req = !(o_if_valid & i_stall);
                grant    = imem_req & i_imem_gnt;
                if (grant) begin
                    state_d = redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    state_d  = S_REQ;
                    buf_load = !redirect;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        if (redirect) begin
            pc_d = target;
        end else if (grant) begin
            pc_d = pc_step(pc_q, PC_INC);
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (grant) begin
                req_pc_q <= pc_q;
            end
        end
    end

    if_fetch_buf u_fetch_buf (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .flush      (redirect),
        .load       (buf_load),
        .stall      (i_stall),
        .load_pc    (req_pc_q),
        .load_instr (i_imem_rdata),
        .valid      (o_if_valid),
        .pc         (o_if_pc),
        .instr      (o_if_instr)
    );

    assign o_imem_req  = i_rst_n & imem_req;
    assign o_flush     = i_rst_n & redirect;
    assign o_imem_addr = pc_q;

endmodule

// File: tb/tb_if_pc_redirect.sv
// Self-checking bench for if_pc_redirect: directed scenarios plus randomized run vs. a transaction model.
`include "rtl/if_pc_redirect_pkg.sv"

module tb_if_pc_redirect;

    localparam logic [63:0] TB_RESET_PC = 64'h0;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_ex_jump_taken;
    logic        i_ex_branch_taken;
    logic [63:0] i_ex_jump_target;
    logic [63:0] i_ex_branch_target;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [63:0] o_if_pc;
    logic [31:0] o_if_instr;
    logic        o_flush;

    int checks = 0;
    int errors = 0;

    // Memory responder state (memory side, not expectation).
    bit          pend;
    logic [63:0] pend_addr;
    int          pend_cnt;
    bit          data_hash;

    logic        obs_req, obs_flush, obs_valid, obs_rvalid;
    logic [63:0] obs_addr, obs_pc;
    logic [31:0] obs_instr, obs_rdata;

    if_pc_redirect #(.RESET_PC(TB_RESET_PC), .PC_INC(4)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_stall            (i_stall),
        .i_ex_jump_taken    (i_ex_jump_taken),
        .i_ex_branch_taken  (i_ex_branch_taken),
        .i_ex_jump_target   (i_ex_jump_target),
        .i_ex_branch_target (i_ex_branch_target),
        .o_imem_req         (o_imem_req),
        .o_imem_addr        (o_imem_addr),
        .i_imem_gnt         (i_imem_gnt),
        .i_imem_rvalid      (i_imem_rvalid),
        .i_imem_rdata       (i_imem_rdata),
        .o_if_valid         (o_if_valid),
        .o_if_pc            (o_if_pc),
        .o_if_instr         (o_if_instr),
        .o_flush            (o_flush)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        if (data_hash) return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
        return 32'h0000_0013;
    endfunction

    // One clock cycle: present memory response, grant if asked, sample outputs, advance.
    task automatic step(input bit gnt_ok, input int lat);
        if (pend && pend_cnt == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_data(pend_addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
            if (pend) pend_cnt--;
        end
        #1;
        i_imem_gnt = gnt_ok && o_imem_req;
        #1;
        obs_req    = o_imem_req;
        obs_addr   = o_imem_addr;
        obs_flush  = o_flush;
        obs_valid  = o_if_valid;
        obs_pc     = o_if_pc;
        obs_instr  = o_if_instr;
        obs_rvalid = i_imem_rvalid;
        obs_rdata  = i_imem_rdata;
        if (i_imem_rvalid) pend = 1'b0;
        if (i_imem_gnt) begin
            pend      = 1'b1;
            pend_addr = o_imem_addr;
            pend_cnt  = lat - 1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_stall            = 1'b0;
        i_ex_jump_taken    = 1'b0;
        i_ex_branch_taken  = 1'b0;
        i_ex_jump_target   = 64'h0;
        i_ex_branch_target = 64'h0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        pend    = 1'b0;
        idle_inputs();
        step(1'b0, 1);
        step(1'b0, 1);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        pend    = 1'b0;
        idle_inputs();
        i_ex_jump_taken    = 1'b1;
        i_ex_branch_taken  = 1'b1;
        i_ex_jump_target   = 64'h4000;
        i_ex_branch_target = 64'h8000;
        step(1'b1, 1);
        checks++;
        if (obs_flush !== 1'b0 || obs_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_gating: got flush=%b req=%b, expected 0 0", obs_flush, obs_req);
        end
        step(1'b1, 1);
        checks++;
        if (obs_valid !== 1'b0 || obs_pc !== 64'h0 || obs_instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_buf: got v=%b pc=%h instr=%h, expected 0 0 0", obs_valid, obs_pc, obs_instr);
        end
        checks++;
        if (obs_addr !== TB_RESET_PC || obs_req !== 1'b0 || obs_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_pc: got addr=%h req=%b flush=%b, expected %h 0 0", obs_addr, obs_req, obs_flush, TB_RESET_PC);
        end
        i_rst_n = 1'b1;
        idle_inputs();
        step(1'b1, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== TB_RESET_PC) begin
            errors++;
            $display("[TB] FAIL rst_release: got req=%b addr=%h, expected 1 %h", obs_req, obs_addr, TB_RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_addr [3];
        exp_addr = '{64'h0, 64'h4, 64'h8};
        data_hash = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1);
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== exp_addr[k]) begin
                errors++;
                $display("[TB] FAIL seq_req%0d: got req=%b addr=%h, expected 1 %h", k, obs_req, obs_addr, exp_addr[k]);
            end
            if (k > 0) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_pc !== exp_addr[k-1] || obs_instr !== 32'h13) begin
                    errors++;
                    $display("[TB] FAIL seq_out%0d: got v=%b pc=%h instr=%h, expected 1 %h 00000013",
                             k, obs_valid, obs_pc, obs_instr, exp_addr[k-1]);
                end
            end
            if (k < 2) begin
                step(1'b1, 1);
                checks++;
                if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL seq_wait%0d: got req=%b v=%b, expected 0 0", k, obs_req, obs_valid);
                end
            end
        end
    endtask

    task automatic test_jump_branch();
        data_hash = 1'b0;
        do_reset();
        i_ex_jump_taken    = 1'b1;
        i_ex_branch_taken  = 1'b1;
        i_ex_jump_target   = 64'h1000;
        i_ex_branch_target = 64'h2000;
        step(1'b0, 1);
        checks++;
        if (obs_flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jb_flush: got %b expected 1", obs_flush);
        end
        idle_inputs();
        step(1'b0, 1);
        checks++;
        if (obs_addr !== 64'h1000 || obs_req !== 1'b1 || obs_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jb_target: got addr=%h req=%b flush=%b, expected 1000 1 0", obs_addr, obs_req, obs_flush);
        end
        i_ex_branch_taken  = 1'b1;
        i_ex_branch_target = 64'h2000;
        i_ex_jump_target   = 64'h3000;
        step(1'b0, 1);
        idle_inputs();
        step(1'b1, 1);
        checks++;
        if (obs_addr !== 64'h2000) begin
            errors++;
            $display("[TB] FAIL br_target: got %h expected 2000", obs_addr);
        end
    endtask

    task automatic test_redirect_on_gnt();
        data_hash = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1);
        i_ex_jump_taken  = 1'b1;
        i_ex_jump_target = 64'h80;
        step(1'b1, 1);
        checks++;
        if (obs_addr !== 64'h8 || obs_req !== 1'b1 || obs_flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rog_grant: got addr=%h req=%b flush=%b, expected 8 1 1", obs_addr, obs_req, obs_flush);
        end
        idle_inputs();
        step(1'b1, 1);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rog_drop: got v=%b req=%b, expected 0 0", obs_valid, obs_req);
        end
        step(1'b1, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 64'h80 || obs_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rog_next: got req=%b addr=%h v=%b, expected 1 80 0", obs_req, obs_addr, obs_valid);
        end
        step(1'b1, 1);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rog_nostale: got v=%b pc=%h, expected v=0", obs_valid, obs_pc);
        end
        step(1'b1, 1);
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 64'h80) begin
            errors++;
            $display("[TB] FAIL rog_out: got v=%b pc=%h, expected 1 80", obs_valid, obs_pc);
        end
    endtask

    task automatic test_stall_hold();
        data_hash = 1'b0;
        do_reset();
        step(1'b1, 1);
        step(1'b1, 1);
        i_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1);
            checks++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== 64'h0 || obs_instr !== 32'h13) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got req=%b v=%b pc=%h instr=%h, expected 0 1 0 00000013",
                         k, obs_req, obs_valid, obs_pc, obs_instr);
            end
        end
        i_stall = 1'b0;
        step(1'b1, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 64'h4 || obs_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: got req=%b addr=%h v=%b, expected 1 4 1", obs_req, obs_addr, obs_valid);
        end
        step(1'b1, 1);
        step(1'b1, 1);
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 64'h4) begin
            errors++;
            $display("[TB] FAIL stall_resume: got v=%b pc=%h, expected 1 4", obs_valid, obs_pc);
        end
    endtask

    task automatic test_wrap();
        data_hash = 1'b0;
        do_reset();
        i_ex_jump_taken  = 1'b1;
        i_ex_jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1'b0, 1);
        idle_inputs();
        step(1'b1, 1);
        checks++;
        if (obs_addr !== 64'hFFFF_FFFF_FFFF_FFFC || obs_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_req: got addr=%h req=%b, expected fffffffffffffffc 1", obs_addr, obs_req);
        end
        step(1'b1, 1);
        step(1'b1, 1);
        checks++;
        if (obs_addr !== 64'h0 || obs_req !== 1'b1 || obs_valid !== 1'b1 || obs_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_next: got addr=%h req=%b v=%b pc=%h, expected 0 1 1 fffffffffffffffc",
                     obs_addr, obs_req, obs_valid, obs_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        data_hash = 1'b0;
        do_reset();
        step(1'b1, 1);
        i_rst_n = 1'b0;
        pend    = 1'b0;
        step(1'b1, 1);
        step(1'b1, 1);
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b0 || obs_addr !== TB_RESET_PC) begin
            errors++;
            $display("[TB] FAIL rmw_reset: got req=%b v=%b addr=%h, expected 0 0 %h", obs_req, obs_valid, obs_addr, TB_RESET_PC);
        end
        i_rst_n = 1'b1;
        step(1'b1, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== TB_RESET_PC) begin
            errors++;
            $display("[TB] FAIL rmw_release: got req=%b addr=%h, expected 1 %h", obs_req, obs_addr, TB_RESET_PC);
        end
    endtask

    // Transaction-level model: architectural PC, one outstanding request (maybe killed), one buffer slot.
    task automatic test_random();
        logic [63:0] m_pc, m_out_pc, m_buf_pc, tgt;
        logic [31:0] m_buf_instr;
        bit          m_out, m_killed, m_buf_valid;
        bit          gnt_ok, exp_req, exp_flush, redir, grant_m, delivered;
        int          lat;
        int          shown = 0;
        data_hash = 1'b1;
        do_reset();
        m_pc = TB_RESET_PC; m_out = 0; m_killed = 0; m_out_pc = 0;
        m_buf_valid = 0; m_buf_pc = 0; m_buf_instr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_rst_n = ($urandom_range(0, 99) != 0);
            if (!i_rst_n) pend = 1'b0;
            i_stall           = ($urandom_range(0, 3) == 0);
            i_ex_jump_taken   = ($urandom_range(0, 9) == 0);
            i_ex_branch_taken = ($urandom_range(0, 9) == 0);
            i_ex_jump_target   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom} & ~64'h3;
            i_ex_branch_target = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom} & ~64'h3;
            gnt_ok = ($urandom_range(0, 3) != 0);
            lat    = $urandom_range(1, 3);

            redir     = i_ex_jump_taken || i_ex_branch_taken;
            tgt       = i_ex_jump_taken ? i_ex_jump_target : i_ex_branch_target;
            exp_req   = i_rst_n && !m_out && !(m_buf_valid && i_stall);
            exp_flush = i_rst_n && redir;

            step(gnt_ok, lat);

            checks++;
            if (obs_req !== exp_req || obs_addr !== m_pc || obs_flush !== exp_flush || obs_valid !== m_buf_valid) begin
                errors++;
                if (shown++ < 20)
                    $display("[TB] FAIL rnd_ctl cyc %0d: got req=%b addr=%h flush=%b v=%b, expected %b %h %b %b",
                             cyc, obs_req, obs_addr, obs_flush, obs_valid, exp_req, m_pc, exp_flush, m_buf_valid);
            end
            if (m_buf_valid) begin
                checks++;
                if (obs_pc !== m_buf_pc || obs_instr !== m_buf_instr) begin
                    errors++;
                    if (shown++ < 20)
                        $display("[TB] FAIL rnd_buf cyc %0d: got pc=%h instr=%h, expected %h %h",
                                 cyc, obs_pc, obs_instr, m_buf_pc, m_buf_instr);
                end
            end

            if (!i_rst_n) begin
                m_pc = TB_RESET_PC; m_out = 0; m_killed = 0;
                m_buf_valid = 0; m_buf_pc = 0; m_buf_instr = 0;
            end else begin
                grant_m   = gnt_ok && exp_req;
                delivered = m_out && obs_rvalid && !m_killed && !redir;
                if (redir) m_buf_valid = 0;
                else if (delivered) begin
                    m_buf_valid = 1; m_buf_pc = m_out_pc; m_buf_instr = obs_rdata;
                end else if (!i_stall) m_buf_valid = 0;
                if (obs_rvalid) m_out = 0;
                if (grant_m) begin
                    m_out = 1; m_out_pc = m_pc; m_killed = redir;
                end else if (m_out && redir) m_killed = 1;
                if (redir) m_pc = tgt;
                else if (grant_m) m_pc = m_pc + 64'd4;
            end
        end
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        pend          = 1'b0;
        pend_addr     = 64'h0;
        pend_cnt      = 0;
        data_hash     = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_jump_branch();
        test_redirect_on_gnt();
        test_stall_hold();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
